counter_driver: RTL and testbench

Host-side controller for the 4-bit up/down counter interface (LOAD, DATA, UD in; DOUT, COUT out). It accepts a start request with an initial value, a target value, a direction and a pass count. It loads the counter, lets it run, and watches DOUT and COUT. It then freezes the counter on the requested target occurrence and reports completion. Between runs it parks the counter by holding LOAD high.

---
 rtl/counter_driver_if.sv | 21 ++
 rtl/counter_driver.sv | 100 ++++++++++
 tb/tb_counter_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/counter_driver_if.sv
// counter_driver_if: host request, counter pins and status of the counter driver
interface counter_driver_if #(parameter int WRAP_W = 4);
    logic              start;
    logic              abort;
    logic [3:0]        init;
    logic [3:0]        target;
    logic              dir;
    logic [WRAP_W-1:0] passes;
    logic [3:0]        dout;
    logic              cout;
    logic              load;
    logic [3:0]        data;
    logic              ud;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wrap_cnt;
    modport master (output start, abort, init, target, dir, passes, dout, cout,
                    input load, data, ud, busy, done, wrap_cnt);
    modport slave (input start, abort, init, target, dir, passes, dout, cout,
                   output load, data, ud, busy, done, wrap_cnt);
endinterface

// File: rtl/counter_driver.sv
// counter_driver: loads a 4-bit up/down counter, lets it run and freezes it on the
// requested TARGET occurrence; the counter is parked with LOAD held high between runs.
module counter_driver #(parameter int WRAP_W = 4) (
    input logic           clk_i,
    input logic           rst_i,
    counter_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOADING, RUN} state_t;
    localparam logic [WRAP_W-1:0] SAT = '1;
    state_t            state_q, state_d;
    logic [3:0]        init_q, init_d, target_q, target_d, park_q, park_d;
    logic              dir_q, dir_d, done_q, done_d;
    logic [WRAP_W-1:0] passes_q, passes_d, pass_q, pass_d, wrap_q, wrap_d;
    logic              load, match, hit, wrap_ev;
    logic [3:0]        data;
    assign match   = bus.dout == target_q;
    assign hit     = match && pass_q == passes_q;
    // COUT right after a wrap lands on 0 (up) or F (down); elsewhere it is a departure
    assign wrap_ev = bus.cout && bus.dout == (dir_q ? 4'h0 : 4'hF);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            init_q   <= '0;
            target_q <= '0;
            park_q   <= '0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
            passes_q <= '0;
            pass_q   <= '0;
            wrap_q   <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            target_q <= target_d;
            park_q   <= park_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            passes_q <= passes_d;
            pass_q   <= pass_d;
            wrap_q   <= wrap_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        target_d = target_q;
        park_d   = park_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        passes_d = passes_q;
        pass_d   = pass_q;
        wrap_d   = wrap_q;
        load     = 1'b1;
        data     = park_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    init_d   = bus.init;
                    target_d = bus.target;
                    dir_d    = bus.dir;
                    passes_d = bus.passes;
                    wrap_d   = '0;
                    pass_d   = '0;
                    state_d  = LOADING;
                end
            end
            LOADING: begin
                data    = init_q;
                state_d = bus.abort ? IDLE : RUN;
                park_d  = bus.abort ? init_q : park_q;
            end
            RUN: begin
                load   = 1'b0;
                data   = target_q;
                wrap_d = (wrap_ev && wrap_q != SAT) ? wrap_q + 1'b1 : wrap_q;
                // abort outranks a hit; both freeze the counter in this same cycle
                if (bus.abort) begin
                    load    = 1'b1;
                    data    = bus.dout;
                    park_d  = bus.dout;
                    state_d = IDLE;
                end else if (hit) begin
                    load    = 1'b1;
                    park_d  = target_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (match && pass_q != SAT) begin
                    pass_d = pass_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.load     = load;
    assign bus.data     = data;
    assign bus.ud       = dir_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.wrap_cnt = wrap_q;
endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver: drives counter_driver against a behavioural 4-bit up/down counter
// and checks run timing, wrap counting, abort and reset behaviour.
module tb_counter_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   miss = 0;
    always #5 clk = ~clk;
    counter_driver_if #(.WRAP_W(4)) bus();
    counter_driver #(.WRAP_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    // counter: COUT rises on the wrap step and stays for one more step (departure)
    logic [3:0] cnt = 4'h0;
    logic       cy = 1'b0;
    logic       wr_q = 1'b0;
    logic       wr;
    assign wr = bus.ud ? cnt == 4'hF : cnt == 4'h0;
    always @(posedge clk) begin
        if (bus.load) begin
            cnt  <= bus.data;
            cy   <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            cnt  <= bus.ud ? cnt + 4'd1 : cnt - 4'd1;
            cy   <= wr || wr_q;
            wr_q <= wr;
        end
    end
    assign bus.dout = cnt;
    assign bus.cout = cy;
    typedef struct { int m; int wrap; int fin; int dir; } exp_t;
    exp_t sb[$];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run(input logic [3:0] ini, input logic [3:0] tgt, input logic dir,
                       input logic [3:0] passes, input int exp_wrap, input bit poke);
        exp_t e;
        int   d;
        int   m;
        bus.init = ini; bus.target = tgt; bus.dir = dir; bus.passes = passes;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        d = dir ? int'(4'(tgt - ini)) : int'(4'(ini - tgt));
        e.m = 2 + d + 16 * int'(passes); e.wrap = exp_wrap; e.fin = int'(tgt); e.dir = int'(dir);
        sb.push_back(e);
        chk("loading_load", bus.load, 1);
        chk("loading_data", bus.data, ini);
        chk("loading_busy", bus.busy, 1);
        chk("loading_ud", bus.ud, dir);
        m = 0;
        while (m < 400) begin
            tick();
            m++;
            if (m == 1) begin
                chk("first_dout", bus.dout, ini);
                chk("first_cout", bus.cout, 0);
                if (poke) begin
                    bus.start = 1'b1; bus.init = ~ini; bus.target = ~tgt; bus.dir = ~dir;
                end
            end
            if (m == 2 && poke) bus.start = 1'b0;
            if (m == sb[0].m - 1) begin
                chk("hit_load", bus.load, 1);
                chk("hit_data", bus.data, tgt);
                chk("hit_busy", bus.busy, 1);
            end
            if (bus.done === 1'b1) break;
        end
        e = sb.pop_front();
        chk("done_cycle", m, e.m);
        chk("wrap_cnt", bus.wrap_cnt, e.wrap);
        chk("done_busy", bus.busy, 0);
        chk("ud_held", bus.ud, e.dir);
        tick();
        chk("done_width", bus.done, 0);
        chk("park_dout", bus.dout, e.fin);
        chk("park_load", bus.load, 1);
    endtask
    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.init = '0; bus.target = '0;
        bus.dir = 1'b0; bus.passes = '0;
        tick(); tick();
        chk("rst_load", bus.load, 1);
        chk("rst_data", bus.data, 0);
        chk("rst_ud", bus.ud, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wrap", bus.wrap_cnt, 0);
        rst = 1'b0;
        tick();
        run(4'h2, 4'h5, 1'b1, 4'd0, 0, 1'b0);
        run(4'h1, 4'hE, 1'b0, 4'd0, 1, 1'b0);
        run(4'h3, 4'h3, 1'b1, 4'd2, 2, 1'b0);
        run(4'h6, 4'h6, 1'b0, 4'd0, 0, 1'b0);
        run(4'h1, 4'h0, 1'b1, 4'd15, 15, 1'b0);
        run(4'h0, 4'h5, 1'b1, 4'd0, 0, 1'b1);
        // abort while the counter shows 9
        bus.init = 4'h7; bus.target = 4'h2; bus.dir = 1'b1; bus.passes = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("abort_dout", bus.dout, 9);
        bus.abort = 1'b1;
        #1;
        chk("abort_load", bus.load, 1);
        chk("abort_data", bus.data, 9);
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        tick(); tick();
        chk("abort_hold", bus.dout, 9);
        chk("abort_done2", bus.done, 0);
        // abort coinciding with a hit
        bus.init = 4'h4; bus.target = 4'h4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.abort = 1'b1;
        #1;
        chk("abhit_load", bus.load, 1);
        chk("abhit_data", bus.data, 4);
        tick();
        bus.abort = 1'b0;
        chk("abhit_done", bus.done, 0);
        chk("abhit_busy", bus.busy, 0);
        tick();
        chk("abhit_hold", bus.dout, 4);
        // reset pulse in the middle of a run
        bus.init = 4'h0; bus.target = 4'h8; bus.dir = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_load", bus.load, 1);
        chk("midrst_data", bus.data, 0);
        chk("midrst_ud", bus.ud, 1);
        tick();
        rst = 1'b0;
        chk("midrst_done", bus.done, 0);
        tick();
        chk("midrst_done2", bus.done, 0);
        chk("midrst_dout", bus.dout, 0);
        run(4'hA, 4'h3, 1'b1, 4'd1, 2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
